// File: rtl/ulpi_receiver.sv
// ULPI receive path: decodes PHY-driven bus cycles into a framed byte stream plus RX CMD status.
// Define ULPI_RX_TIMESTAMP_EN to add a free-running 16-bit counter and the rx_ts sop timestamp.
module ulpi_receiver #(
    parameter int unsigned MAX_PKT_LEN = 1027,
    parameter int unsigned LEN_W       = 11
) (
    input  logic             clk_ULPI,
    input  logic             rst,
    input  logic             DIR,
    input  logic             NXT,
    input  logic [7:0]       DATA_I,
    output logic             busy,
    output logic [7:0]       DATA_O,
    output logic             STP,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             rx_sop,
    output logic             rx_eop,
    output logic             rx_err,
    output logic [LEN_W-1:0] pkt_len,
    output logic [1:0]       line_state,
    output logic [1:0]       vbus_state,
    output logic             host_disc,
`ifdef ULPI_RX_TIMESTAMP_EN
    output logic [15:0]      rx_ts,
`endif
    output logic             rx_cmd_valid
);

    typedef enum logic [2:0] {StSync, StIdle, StTurn, StCmd, StPkt} state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] count_q, count_d, pkt_len_q, pkt_len_d;
    logic             ovf_q, ovf_d, err_q, err_d, sop_pend_q, sop_pend_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d, rx_sop_q, rx_sop_d;
    logic             rx_eop_q, rx_eop_d, rx_err_q, rx_err_d;
    logic [1:0]       line_q, line_d, vbus_q, vbus_d;
    logic             host_q, host_d, cmd_valid_q, cmd_valid_d;
    logic             arm, take_byte, take_cmd, end_pkt, err_set;
    logic [1:0]       rx_event;

    assign rx_event = DATA_I[5:4];

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        ovf_d       = ovf_q;
        err_d       = err_q;
        sop_pend_d  = sop_pend_q;
        pkt_len_d   = pkt_len_q;
        rx_data_d   = rx_data_q;
        line_d      = line_q;
        vbus_d      = vbus_q;
        host_d      = host_q;
        rx_valid_d  = 1'b0;
        rx_sop_d    = 1'b0;
        rx_eop_d    = 1'b0;
        rx_err_d    = 1'b0;
        cmd_valid_d = 1'b0;
        arm         = 1'b0;
        take_byte   = 1'b0;
        take_cmd    = 1'b0;
        end_pkt     = 1'b0;
        err_set     = 1'b0;

        unique case (state_q)
            StSync: if (!DIR) state_d = StIdle;
            StIdle: if (DIR) state_d = StTurn;
            StTurn: begin
                if (!DIR) begin
                    state_d = StIdle;
                end else if (NXT) begin
                    arm     = 1'b1;
                    state_d = StPkt;
                end else begin
                    state_d = StCmd;
                end
            end
            StCmd: begin
                if (!DIR) begin
                    state_d = StIdle;
                end else if (NXT) begin
                    arm       = 1'b1;
                    take_byte = 1'b1;
                    state_d   = StPkt;
                end else begin
                    take_cmd = 1'b1;
                    // RxEvent 01/11 both carry RxActive=1
                    if (rx_event[0]) begin
                        arm     = 1'b1;
                        state_d = StPkt;
                    end
                end
            end
            StPkt: begin
                if (!DIR) begin
                    end_pkt = 1'b1;
                    state_d = StIdle;
                end else if (NXT) begin
                    take_byte = 1'b1;
                end else begin
                    take_cmd = 1'b1;
                    err_set  = (rx_event == 2'b11);
                    if (!rx_event[0]) begin
                        end_pkt = 1'b1;
                        state_d = StCmd;
                    end
                end
            end
            default: state_d = StSync;
        endcase

        // A new packet frame starts clean even if it never carries a byte.
        if (arm) begin
            count_d    = '0;
            ovf_d      = 1'b0;
            err_d      = 1'b0;
            sop_pend_d = 1'b1;
        end
        if (take_byte) begin
            if (count_d < LEN_W'(MAX_PKT_LEN)) begin
                rx_valid_d = 1'b1;
                rx_data_d  = DATA_I;
                rx_sop_d   = sop_pend_d;
                sop_pend_d = 1'b0;
                count_d    = count_d + LEN_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (take_cmd) begin
            line_d      = DATA_I[1:0];
            vbus_d      = DATA_I[3:2];
            host_d      = (rx_event == 2'b10);
            cmd_valid_d = 1'b1;
        end
        if (err_set) err_d = 1'b1;
        if (end_pkt) begin
            rx_eop_d   = 1'b1;
            rx_err_d   = err_q | ovf_q;
            pkt_len_d  = count_q;
            sop_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_ULPI or negedge rst) begin
        if (!rst) begin
            state_q     <= StSync;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            sop_pend_q  <= 1'b0;
            pkt_len_q   <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            rx_sop_q    <= 1'b0;
            rx_eop_q    <= 1'b0;
            rx_err_q    <= 1'b0;
            line_q      <= '0;
            vbus_q      <= '0;
            host_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            sop_pend_q  <= sop_pend_d;
            pkt_len_q   <= pkt_len_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_sop_q    <= rx_sop_d;
            rx_eop_q    <= rx_eop_d;
            rx_err_q    <= rx_err_d;
            line_q      <= line_d;
            vbus_q      <= vbus_d;
            host_q      <= host_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end

`ifdef ULPI_RX_TIMESTAMP_EN
    logic [15:0] ts_q, ts_d, rx_ts_q, rx_ts_d;

    always_comb begin
        ts_d    = ts_q + 16'd1;
        rx_ts_d = rx_sop_d ? ts_q : rx_ts_q;
    end

    always_ff @(posedge clk_ULPI or negedge rst) begin
        if (!rst) begin
            ts_q    <= '0;
            rx_ts_q <= '0;
        end else begin
            ts_q    <= ts_d;
            rx_ts_q <= rx_ts_d;
        end
    end

    assign rx_ts = rx_ts_q;
`endif

    assign busy         = (state_q != StSync) && (state_q != StIdle);
    assign DATA_O       = 8'h00;
    assign STP          = 1'b0;
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign rx_sop       = rx_sop_q;
    assign rx_eop       = rx_eop_q;
    assign rx_err       = rx_err_q;
    assign pkt_len      = pkt_len_q;
    assign line_state   = line_q;
    assign vbus_state   = vbus_q;
    assign host_disc    = host_q;
    assign rx_cmd_valid = cmd_valid_q;

endmodule

// File: tb/tb_ulpi_receiver.sv
// Bench for ulpi_receiver: transaction-level expectations built from bus scenarios,
// compared against what a negedge monitor collects from the DUT outputs.
module tb_ulpi_receiver;
    localparam int MAX = 1027;
    localparam int LW  = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          DIR = 1'b0, NXT = 1'b0;
    logic [7:0]    DATA_I = 8'h00;
    logic          busy, STP, rx_valid, rx_sop, rx_eop, rx_err, host_disc, rx_cmd_valid;
    logic [7:0]    DATA_O, rx_data;
    logic [LW-1:0] pkt_len;
    logic [1:0]    line_state, vbus_state;
`ifdef ULPI_RX_TIMESTAMP_EN
    logic [15:0]   rx_ts;
`endif

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int overlap = 0;

    logic [8:0]  got_b[$], exp_b[$];   // {sop, data}
    logic [LW:0] got_e[$], exp_e[$];   // {err, len}
    int          got_ec[$];
    logic [4:0]  got_c[$], exp_c[$];   // {host_disc, vbus, line}

    ulpi_receiver #(.MAX_PKT_LEN(MAX), .LEN_W(LW)) dut (
        .clk_ULPI    (clk),
        .rst         (rst),
        .DIR         (DIR),
        .NXT         (NXT),
        .DATA_I      (DATA_I),
        .busy        (busy),
        .DATA_O      (DATA_O),
        .STP         (STP),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_sop      (rx_sop),
        .rx_eop      (rx_eop),
        .rx_err      (rx_err),
        .pkt_len     (pkt_len),
        .line_state  (line_state),
        .vbus_state  (vbus_state),
        .host_disc   (host_disc),
`ifdef ULPI_RX_TIMESTAMP_EN
        .rx_ts       (rx_ts),
`endif
        .rx_cmd_valid(rx_cmd_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    always @(negedge clk) begin
        if (rx_valid) got_b.push_back({rx_sop, rx_data});
        if (rx_eop) begin
            got_e.push_back({rx_err, pkt_len});
            got_ec.push_back(cyc_cnt);
        end
        if (rx_eop && rx_valid) overlap++;
        if (rx_cmd_valid) got_c.push_back({host_disc, vbus_state, line_state});
    end

    task automatic drive(input logic d, input logic n, input logic [7:0] b);
        DIR = d; NXT = n; DATA_I = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic clr();
        got_b.delete(); exp_b.delete(); got_e.delete(); exp_e.delete();
        got_ec.delete(); got_c.delete(); exp_c.delete();
    endtask

    function automatic logic [4:0] cmd_fields(input logic [7:0] b);
        return {b[5:4] == 2'b10, b[3:2], b[1:0]};
    endfunction

    task automatic send_cmd(input logic [7:0] b);
        drive(1'b1, 1'b0, b);
        exp_c.push_back(cmd_fields(b));
    endtask

    task automatic test_reset();
        rst = 1'b0; DIR = 1'b1; NXT = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, rx_valid, rx_sop, rx_eop, rx_err, host_disc, rx_cmd_valid} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {busy, rx_valid, rx_sop, rx_eop, rx_err, host_disc, rx_cmd_valid});
        end
        checks++;
        if ({pkt_len, line_state, vbus_state} !== '0) begin
            errors++;
            $display("FAIL reset_fields: got len=%0d line=%b vbus=%b want 0",
                     pkt_len, line_state, vbus_state);
        end
        rst = 1'b1;
        clr();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 8'h05);
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL sync_busy cycle %0d: got %b want 0", i, busy);
            end
        end
        idle(2);
        checks++;
        if (got_c.size() != 0) begin
            errors++;
            $display("FAIL sync_no_cmd: got %0d rx_cmd_valid want 0", got_c.size());
        end
    endtask

    task automatic test_rx_cmd();
        logic [7:0] b;
        clr();
        drive(1'b1, 1'b0, 8'($urandom));
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL turn_busy: got %b want 1", busy);
        end
        drive(1'b1, 1'b0, 8'($urandom));
        send_cmd(8'h05);
        checks++;
        if (line_state !== 2'b01 || vbus_state !== 2'b01 || rx_cmd_valid !== 1'b1) begin
            errors++;
            $display("FAIL cmd_05: got line=%b vbus=%b v=%b want 01 01 1",
                     line_state, vbus_state, rx_cmd_valid);
        end
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            b[5:4] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
            send_cmd(b);
        end
        idle(3);
        checks++;
        if (got_c.size() != exp_c.size()) begin
            errors++;
            $display("FAIL cmd_count: got %0d want %0d", got_c.size(), exp_c.size());
        end
        foreach (exp_c[i]) if (i < got_c.size()) begin
            checks++;
            if (got_c[i] !== exp_c[i]) begin
                errors++;
                $display("FAIL cmd_fields[%0d]: got %b want %b", i, got_c[i], exp_c[i]);
            end
        end
        checks++;
        if (got_b.size() != 0 || got_e.size() != 0) begin
            errors++;
            $display("FAIL cmd_no_data: got %0d bytes %0d eops want 0 0",
                     got_b.size(), got_e.size());
        end
    endtask

    task automatic test_packet_cmd_start();
        logic [7:0] d[3] = '{8'hA5, 8'hC3, 8'h01};
        clr();
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        send_cmd(8'h10);
        foreach (d[i]) begin
            drive(1'b1, 1'b1, d[i]);
            exp_b.push_back({i == 0, d[i]});
        end
        send_cmd(8'h00);
        idle(3);
        exp_e.push_back({1'b0, LW'(3)});
        checks++;
        if (got_b.size() != 3) begin
            errors++;
            $display("FAIL pkt3_count: got %0d want 3", got_b.size());
        end
        foreach (exp_b[i]) if (i < got_b.size()) begin
            checks++;
            if (got_b[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL pkt3_byte[%0d]: got %h want %h", i, got_b[i], exp_b[i]);
            end
        end
        checks++;
        if (got_e.size() != 1 || got_e[0] !== exp_e[0]) begin
            errors++;
            $display("FAIL pkt3_eop: got n=%0d val=%h want 1 %h",
                     got_e.size(), got_e.size() ? got_e[0] : '0, exp_e[0]);
        end
    endtask

    task automatic test_packet_dir_end();
        int rel;
        clr();
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'hFF);
        drive(1'b1, 1'b1, 8'h2D);
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
        rel = cyc_cnt;
        idle(3);
        checks++;
        if (got_b.size() != 2 || got_b[0] !== 9'h12D || got_b[1] !== 9'h000) begin
            errors++;
            $display("FAIL dir_end_bytes: got n=%0d want 2 bytes 12d 000", got_b.size());
        end
        checks++;
        if (got_e.size() != 1 || got_e[0] !== {1'b0, LW'(2)} || got_ec[0] != rel) begin
            errors++;
            $display("FAIL dir_end_eop: got n=%0d val=%h cyc=%0d want 1 002 cyc=%0d",
                     got_e.size(), got_e.size() ? got_e[0] : '0,
                     got_ec.size() ? got_ec[0] : -1, rel);
        end
    endtask

    task automatic test_random_packets();
        int         n;
        logic       err;
        logic [7:0] b, d;
        clr();
        for (int p = 0; p < 10; p++) begin
            n   = (p == 0) ? 0 : $urandom_range(0, 12);
            err = 1'b0;
            drive(1'b1, 1'b0, 8'($urandom));
            if ($urandom_range(0, 1) != 0) begin
                drive(1'b1, 1'b0, 8'($urandom));
                b = 8'($urandom);
                b[5:4] = 2'b01;
                send_cmd(b);
            end else begin
                drive(1'b1, 1'b1, 8'($urandom));
            end
            for (int i = 0; i < n; i++) begin
                if (i > 0 && $urandom_range(0, 3) == 0) begin
                    b = 8'($urandom);
                    b[5:4] = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b01;
                    if (b[5:4] == 2'b11) err = 1'b1;
                    send_cmd(b);
                end
                d = 8'($urandom);
                drive(1'b1, 1'b1, d);
                exp_b.push_back({i == 0, d});
            end
            if ($urandom_range(0, 1) != 0) begin
                b = 8'($urandom);
                b[5:4] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00;
                send_cmd(b);
            end
            idle($urandom_range(1, 3));
            exp_e.push_back({err, LW'(n)});
        end
        idle(2);
        checks++;
        if (got_b.size() != exp_b.size()) begin
            errors++;
            $display("FAIL rnd_byte_count: got %0d want %0d", got_b.size(), exp_b.size());
        end
        foreach (exp_b[i]) if (i < got_b.size()) begin
            checks++;
            if (got_b[i] !== exp_b[i]) begin
                errors++;
                $display("FAIL rnd_byte[%0d]: got %h want %h", i, got_b[i], exp_b[i]);
            end
        end
        checks++;
        if (got_e.size() != exp_e.size()) begin
            errors++;
            $display("FAIL rnd_eop_count: got %0d want %0d", got_e.size(), exp_e.size());
        end
        foreach (exp_e[i]) if (i < got_e.size()) begin
            checks++;
            if (got_e[i] !== exp_e[i]) begin
                errors++;
                $display("FAIL rnd_eop[%0d]: got %h want %h", i, got_e[i], exp_e[i]);
            end
        end
        checks++;
        if (got_c != exp_c) begin
            errors++;
            $display("FAIL rnd_cmds: got %0d cmds want %0d (contents differ)",
                     got_c.size(), exp_c.size());
        end
    endtask

    task automatic test_error_overflow();
        clr();
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'h00);
        repeat (3) drive(1'b1, 1'b1, 8'($urandom));
        drive(1'b1, 1'b0, 8'h30);
        repeat (2) drive(1'b1, 1'b1, 8'($urandom));
        drive(1'b1, 1'b0, 8'h00);
        idle(2);
        checks++;
        if (got_e.size() != 1 || got_e[0] !== {1'b1, LW'(5)}) begin
            errors++;
            $display("FAIL rxerr_eop: got n=%0d val=%h want 1 %h",
                     got_e.size(), got_e.size() ? got_e[0] : '0, {1'b1, LW'(5)});
        end
        clr();
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'h00);
        for (int i = 0; i < MAX + 2; i++) drive(1'b1, 1'b1, 8'(i));
        idle(3);
        checks++;
        if (got_b.size() != MAX) begin
            errors++;
            $display("FAIL ovf_bytes: got %0d want %0d", got_b.size(), MAX);
        end
        checks++;
        if (got_b.size() == MAX && (got_b[0] !== 9'h100 || got_b[MAX-1] !== {1'b0, 8'(MAX-1)}))
        begin
            errors++;
            $display("FAIL ovf_first_last: got %h %h want 100 %h",
                     got_b[0], got_b[MAX-1], {1'b0, 8'(MAX-1)});
        end
        checks++;
        if (got_e.size() != 1 || got_e[0] !== {1'b1, LW'(MAX)}) begin
            errors++;
            $display("FAIL ovf_eop: got n=%0d val=%h want 1 %h",
                     got_e.size(), got_e.size() ? got_e[0] : '0, {1'b1, LW'(MAX)});
        end
    endtask

    task automatic test_back_to_back();
        clr();
        overlap = 0;
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        send_cmd(8'h10);
        drive(1'b1, 1'b1, 8'h11);
        drive(1'b1, 1'b1, 8'h22);
        send_cmd(8'h20);
        send_cmd(8'h1F);
        drive(1'b1, 1'b1, 8'h33);
        drive(1'b1, 1'b1, 8'h44);
        drive(1'b1, 1'b1, 8'h55);
        send_cmd(8'h00);
        send_cmd(8'h10);
        send_cmd(8'h00);
        idle(3);
        exp_e = '{{1'b0, LW'(2)}, {1'b0, LW'(3)}, {1'b0, LW'(0)}};
        exp_b = '{9'h111, 9'h022, 9'h133, 9'h044, 9'h055};
        checks++;
        if (got_e != exp_e) begin
            errors++;
            $display("FAIL b2b_eops: got %0d eops want 3 (002,003,000)", got_e.size());
        end
        checks++;
        if (got_b != exp_b) begin
            errors++;
            $display("FAIL b2b_bytes: got %0d bytes want 5 (111,022,133,044,055)", got_b.size());
        end
        checks++;
        if (got_c.size() != 6 || got_c[1] !== 5'b10000) begin
            errors++;
            $display("FAIL b2b_host_disc: got n=%0d c1=%b want 6 10000",
                     got_c.size(), got_c.size() > 1 ? got_c[1] : '0);
        end
        checks++;
        if (overlap != 0) begin
            errors++;
            $display("FAIL eop_valid_overlap: got %0d want 0", overlap);
        end
    endtask

    task automatic test_reset_mid_packet();
        clr();
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'hAA);
        drive(1'b1, 1'b1, 8'hBB);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 8'hCC);
        checks++;
        if (got_e.size() != 0 || busy !== 1'b0 || pkt_len !== '0) begin
            errors++;
            $display("FAIL rst_mid_pkt: got eops=%0d busy=%b len=%0d want 0 0 0",
                     got_e.size(), busy, pkt_len);
        end
        clr();
        idle(1);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'h7E);
        idle(3);
        checks++;
        if (got_b.size() != 1 || got_b[0] !== 9'h17E || got_e.size() != 1
            || got_e[0] !== {1'b0, LW'(1)}) begin
            errors++;
            $display("FAIL rst_restart: got bytes=%0d eops=%0d want 1 1",
                     got_b.size(), got_e.size());
        end
    endtask

`ifdef ULPI_RX_TIMESTAMP_EN
    task automatic test_timestamp();
        logic [15:0] ts0;
        rst = 1'b0; DIR = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        clr();
        idle(97);
        drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 8'hAB);
        ts0 = rx_ts;
        checks++;
        if (rx_sop !== 1'b1 || ts0 < 16'd99 || ts0 > 16'd101) begin
            errors++;
            $display("FAIL ts_sop: got sop=%b ts=%0d want 1 100+/-1", rx_sop, ts0);
        end
        drive(1'b1, 1'b1, 8'hCD);
        idle(3);
        checks++;
        if (rx_ts !== ts0 || got_e.size() != 1) begin
            errors++;
            $display("FAIL ts_hold: got ts=%0d eops=%0d want %0d 1", rx_ts, got_e.size(), ts0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_rx_cmd();
        test_packet_cmd_start();
        test_packet_dir_end();
        test_random_packets();
        test_error_overflow();
        test_back_to_back();
        test_reset_mid_packet();
`ifdef ULPI_RX_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
